muldiv_sched: RTL and testbench

- Sequences the shared MULT and DIV units on behalf of the multi-cycle controller, and owns the architectural HI/LO registers.
- Accepts one HI/LO-class op at a time: MULT, MULTU, DIV, DIVU, MTHI, MTLO, MFHI, MFLO.
- Drives each unit's start/busy handshake, writes the results back to HI/LO, and holds the controller in a stall until the op completes.
- Sits between the controller/regfile and the MULT/DIV datapath blocks.

---
 rtl/muldiv_pkg.sv | 27 ++
 rtl/muldiv_hilo.sv | 50 +++++
 rtl/muldiv_sched.sv | 190 +++++++++++++++++++
 tb/tb_muldiv_sched.sv | 386 ++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/muldiv_pkg.sv
// muldiv_pkg: op codes, FSM state encoding and default timeout
// shared by the HI/LO scheduler and its register file.
package muldiv_pkg;

    typedef enum logic [2:0] {
        OP_MULT  = 3'd0,
        OP_MULTU = 3'd1,
        OP_DIV   = 3'd2,
        OP_DIVU  = 3'd3,
        OP_MTHI  = 3'd4,
        OP_MTLO  = 3'd5,
        OP_MFHI  = 3'd6,
        OP_MFLO  = 3'd7
    } op_e;

    typedef enum logic [2:0] {
        S_IDLE     = 3'd0,
        S_M_LAUNCH = 3'd1,
        S_M_WAIT   = 3'd2,
        S_D_LAUNCH = 3'd3,
        S_D_WAIT   = 3'd4,
        S_WB       = 3'd5
    } state_e;

    localparam int DEF_TIMEOUT = 64;

endpackage

// File: rtl/muldiv_hilo.sv
// muldiv_hilo: HI/LO registers with MT/MULT/DIV write mux and a
// registered MF read port. Ports: write strobes + data, hi, lo, mf_data.
module muldiv_hilo
    import muldiv_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               mt_we,
    input  logic               mt_hi,
    input  logic [WIDTH-1:0]   mt_data,
    input  logic               mult_we,
    input  logic [2*WIDTH-1:0] mult_z,
    input  logic               div_we,
    input  logic [WIDTH-1:0]   div_q,
    input  logic [WIDTH-1:0]   div_r,
    input  logic               mf_re,
    input  logic               mf_hi,
    output logic [WIDTH-1:0]   hi,
    output logic [WIDTH-1:0]   lo,
    output logic [WIDTH-1:0]   mf_data
);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            hi      <= '0;
            lo      <= '0;
            mf_data <= '0;
        end else begin
            unique case (1'b1)
                mt_we: begin
                    if (mt_hi) hi <= mt_data;
                    else       lo <= mt_data;
                end
                mult_we: begin
                    hi <= mult_z[2*WIDTH-1:WIDTH];
                    lo <= mult_z[WIDTH-1:0];
                end
                div_we: begin
                    lo <= div_q;
                    hi <= div_r;
                end
                default: ;
            endcase
            if (mf_re) mf_data <= mf_hi ? hi : lo;
        end
    end

endmodule

// File: rtl/muldiv_sched.sv
// muldiv_sched: sequences MULT/DIV units, owns HI/LO, stalls the controller.
// Ports: req handshake, done/mf/hi/lo, unit start/busy/result, error pulses.
// Optional MULDIV_DIV0_TRAP_EN: zero-divisor DIV/DIVU traps without launch.
module muldiv_sched
    import muldiv_pkg::*;
#(
    parameter int WIDTH   = 32,
    parameter int TIMEOUT = DEF_TIMEOUT
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               req_valid,
    input  logic [2:0]         req_op,
    input  logic [WIDTH-1:0]   req_rs,
    input  logic [WIDTH-1:0]   req_rt,
    output logic               req_ready,
    output logic               stall,
    output logic               done,
    output logic [WIDTH-1:0]   mf_data,
    output logic               mf_valid,
    output logic [WIDTH-1:0]   hi,
    output logic [WIDTH-1:0]   lo,
    output logic               mult_start,
    output logic               mult_signed,
    output logic [WIDTH-1:0]   mult_a,
    output logic [WIDTH-1:0]   mult_b,
    input  logic               mult_busy,
    input  logic [2*WIDTH-1:0] mult_z,
    output logic               div_start,
    output logic               div_signed,
    output logic [WIDTH-1:0]   div_dividend,
    output logic [WIDTH-1:0]   div_divisor,
    input  logic               div_busy,
    input  logic [WIDTH-1:0]   div_q,
    input  logic [WIDTH-1:0]   div_r,
    output logic               div_by_zero,
    output logic               timeout_err
);

    localparam int CW = $clog2(TIMEOUT + 1);
    localparam logic [CW-1:0] CNT_MAX = CW'(TIMEOUT - 1);

    state_e        state;
    op_e           op;
    logic          rdy;
    logic [CW-1:0] cnt;
    logic          seen_busy;
    logic          is_mul;
    logic          accept;
    logic          op_mul;
    logic          op_div;
    logic          op_mt;
    logic          op_mf;
    logic          div0;
    logic          wait_busy;

    assign op        = op_e'(req_op);
    assign accept    = req_valid & rdy;
    assign req_ready = rdy;
    assign stall     = req_valid & ~rdy;

    assign op_mul = (op == OP_MULT) || (op == OP_MULTU);
    assign op_div = (op == OP_DIV)  || (op == OP_DIVU);
    assign op_mt  = (op == OP_MTHI) || (op == OP_MTLO);
    assign op_mf  = (op == OP_MFHI) || (op == OP_MFLO);

`ifdef MULDIV_DIV0_TRAP_EN
    assign div0 = (req_rt == '0);
`else
    assign div0 = 1'b0;
`endif

    // One shared WAIT handler; the state picks which unit we listen to.
    assign wait_busy = (state == S_M_WAIT) ? mult_busy : div_busy;

    muldiv_hilo #(.WIDTH(WIDTH)) u_hilo (
        .clk     (clk),
        .rst     (rst),
        .mt_we   (accept & op_mt),
        .mt_hi   (op == OP_MTHI),
        .mt_data (req_rs),
        .mult_we ((state == S_WB) & is_mul),
        .mult_z  (mult_z),
        .div_we  ((state == S_WB) & ~is_mul),
        .div_q   (div_q),
        .div_r   (div_r),
        .mf_re   (accept & op_mf),
        .mf_hi   (op == OP_MFHI),
        .hi      (hi),
        .lo      (lo),
        .mf_data (mf_data)
    );

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state        <= S_IDLE;
            rdy          <= 1'b0;
            cnt          <= '0;
            seen_busy    <= 1'b0;
            is_mul       <= 1'b0;
            done         <= 1'b0;
            mf_valid     <= 1'b0;
            mult_start   <= 1'b0;
            mult_signed  <= 1'b0;
            mult_a       <= '0;
            mult_b       <= '0;
            div_start    <= 1'b0;
            div_signed   <= 1'b0;
            div_dividend <= '0;
            div_divisor  <= '0;
            div_by_zero  <= 1'b0;
            timeout_err  <= 1'b0;
        end else begin
            done        <= 1'b0;
            mf_valid    <= 1'b0;
            mult_start  <= 1'b0;
            div_start   <= 1'b0;
            div_by_zero <= 1'b0;
            timeout_err <= 1'b0;
            unique case (state)
                S_IDLE: begin
                    rdy <= 1'b1;
                    if (accept) begin
                        unique case (1'b1)
                            op_mul: begin
                                state       <= S_M_LAUNCH;
                                rdy         <= 1'b0;
                                is_mul      <= 1'b1;
                                mult_start  <= 1'b1;
                                mult_signed <= (op == OP_MULT);
                                mult_a      <= req_rs;
                                mult_b      <= req_rt;
                            end
                            op_div && div0: begin
                                div_by_zero <= 1'b1;
                                done        <= 1'b1;
                            end
                            op_div && !div0: begin
                                state        <= S_D_LAUNCH;
                                rdy          <= 1'b0;
                                is_mul       <= 1'b0;
                                div_start    <= 1'b1;
                                div_signed   <= (op == OP_DIV);
                                div_dividend <= req_rs;
                                div_divisor  <= req_rt;
                            end
                            op_mt: done <= 1'b1;
                            op_mf: begin
                                done     <= 1'b1;
                                mf_valid <= 1'b1;
                            end
                            default: ;
                        endcase
                    end
                end
                S_M_LAUNCH: begin
                    state     <= S_M_WAIT;
                    cnt       <= '0;
                    seen_busy <= 1'b0;
                end
                S_D_LAUNCH: begin
                    state     <= S_D_WAIT;
                    cnt       <= '0;
                    seen_busy <= 1'b0;
                end
                S_M_WAIT, S_D_WAIT: begin
                    // Busy must be seen once before a low level means done.
                    if (wait_busy) seen_busy <= 1'b1;
                    if (seen_busy && !wait_busy) begin
                        state <= S_WB;
                    end else if (cnt == CNT_MAX) begin
                        timeout_err <= 1'b1;
                        done        <= 1'b1;
                        state       <= S_IDLE;
                        rdy         <= 1'b1;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                S_WB: begin
                    done  <= 1'b1;
                    state <= S_IDLE;
                    rdy   <= 1'b1;
                end
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_muldiv_sched.sv
// tb_muldiv_sched: directed bench with behavioural HI/LO model, unit
// emulators and a per-cycle compare process for muldiv_sched.
module tb_muldiv_sched;
    import muldiv_pkg::*;

    localparam int W   = 32;
    localparam int TO  = 64;
    localparam int MB  = 3;
    localparam int DB  = 5;

    logic          clk = 1'b0;
    logic          rst = 1'b0;
    logic          req_valid = 1'b0;
    logic [2:0]    req_op = 3'd0;
    logic [W-1:0]  req_rs = '0;
    logic [W-1:0]  req_rt = '0;
    logic          req_ready;
    logic          stall;
    logic          done;
    logic [W-1:0]  mf_data;
    logic          mf_valid;
    logic [W-1:0]  hi;
    logic [W-1:0]  lo;
    logic          mult_start;
    logic          mult_signed;
    logic [W-1:0]  mult_a;
    logic [W-1:0]  mult_b;
    logic          mult_busy = 1'b0;
    logic [2*W-1:0] mult_z = '0;
    logic          div_start;
    logic          div_signed;
    logic [W-1:0]  div_dividend;
    logic [W-1:0]  div_divisor;
    logic          div_busy = 1'b0;
    logic [W-1:0]  div_q = '0;
    logic [W-1:0]  div_r = '0;
    logic          div_by_zero;
    logic          timeout_err;

    int n_chk = 0;
    int n_fail = 0;

    logic [W-1:0] exp_hi = '0;
    logic [W-1:0] exp_lo = '0;
    logic [W-1:0] p_hi = '0;
    logic [W-1:0] p_lo = '0;
    logic [W-1:0] p_mfdata = '0;
    logic         p_mf = 1'b0;
    logic         p_to = 1'b0;
    logic         p_dz = 1'b0;

    logic         mult_dead = 1'b0;
    logic         hold_en = 1'b0;
    logic [2:0]   hold_op = 3'd0;
    int           ms_cnt = 0;
    int           ds_cnt = 0;
    int           mc = 0;
    int           dc = 0;
    logic [2*W-1:0] m_res = '0;
    logic [W-1:0] dq_res = '0;
    logic [W-1:0] dr_res = '0;

    muldiv_sched dut (
        .clk          (clk),
        .rst          (rst),
        .req_valid    (req_valid),
        .req_op       (req_op),
        .req_rs       (req_rs),
        .req_rt       (req_rt),
        .req_ready    (req_ready),
        .stall        (stall),
        .done         (done),
        .mf_data      (mf_data),
        .mf_valid     (mf_valid),
        .hi           (hi),
        .lo           (lo),
        .mult_start   (mult_start),
        .mult_signed  (mult_signed),
        .mult_a       (mult_a),
        .mult_b       (mult_b),
        .mult_busy    (mult_busy),
        .mult_z       (mult_z),
        .div_start    (div_start),
        .div_signed   (div_signed),
        .div_dividend (div_dividend),
        .div_divisor  (div_divisor),
        .div_busy     (div_busy),
        .div_q        (div_q),
        .div_r        (div_r),
        .div_by_zero  (div_by_zero),
        .timeout_err  (timeout_err)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [63:0] act,
                       input logic [63:0] want);
        n_chk++;
        if (act !== want) begin
            n_fail++;
            $display("FAIL %s: got %h want %h", nm, act, want);
        end
    endtask

    task automatic tick;
        @(negedge clk);
        #1;
    endtask

    function automatic logic [63:0] mul_ref(input logic sg,
                                            input logic [31:0] a,
                                            input logic [31:0] b);
        logic [63:0] sa;
        logic [63:0] sb;
        if (sg) begin
            sa = {{32{a[31]}}, a};
            sb = {{32{b[31]}}, b};
        end else begin
            sa = {32'b0, a};
            sb = {32'b0, b};
        end
        return sa * sb;
    endfunction

    // Unit behaviour on a zero divisor: q all ones, r = dividend.
    task automatic div_ref(input logic sg, input logic [31:0] a,
                           input logic [31:0] b,
                           output logic [31:0] q, output logic [31:0] r);
        if (b == 32'd0) begin
            q = '1;
            r = a;
        end else if (sg) begin
            q = $signed(a) / $signed(b);
            r = $signed(a) % $signed(b);
        end else begin
            q = a / b;
            r = a % b;
        end
    endtask

    // MULT/DIV unit emulators: busy for a fixed number of cycles,
    // garbage on the result bus until busy drops.
    initial forever begin
        @(negedge clk);
        if (!rst) begin
            mc = 0;
            dc = 0;
            mult_busy = 1'b0;
            div_busy = 1'b0;
            mult_z = '0;
            div_q = '0;
            div_r = '0;
        end else begin
            if (mult_start) begin
                ms_cnt++;
                if (!mult_dead) begin
                    mc = MB;
                    m_res = mul_ref(mult_signed, mult_a, mult_b);
                end
            end
            mult_busy = (mc != 0);
            if (mc != 0) mc--;
            mult_z = mult_busy ? 64'hBAD0_BAD0_BAD0_BAD0 : m_res;
            if (div_start) begin
                ds_cnt++;
                dc = DB;
                div_ref(div_signed, div_dividend, div_divisor,
                        dq_res, dr_res);
            end
            div_busy = (dc != 0);
            if (dc != 0) dc--;
            div_q = div_busy ? 32'hBAD0_BAD0 : dq_res;
            div_r = div_busy ? 32'hBAD1_BAD1 : dr_res;
        end
    end

    // Per-cycle compare against the architectural HI/LO model.
    initial forever begin
        @(negedge clk);
        if (!rst) begin
            exp_hi = '0;
            exp_lo = '0;
        end else begin
            chk("stall", stall, req_valid & ~req_ready);
            if (done) begin
                exp_hi = p_hi;
                exp_lo = p_lo;
                chk("mf_valid", mf_valid, p_mf);
                if (p_mf) chk("mf_data", mf_data, p_mfdata);
                chk("timeout_err", timeout_err, p_to);
                chk("div_by_zero", div_by_zero, p_dz);
            end else begin
                chk("quiet_pulses", {mf_valid, timeout_err, div_by_zero}, 0);
            end
            chk("hi", hi, exp_hi);
            chk("lo", lo, exp_lo);
        end
    end

    task automatic run_op(input logic [2:0] op, input logic [31:0] rs,
                          input logic [31:0] rt, input int lat);
        int n;
        int ms0;
        int ds0;
        logic is_m;
        logic is_d;
        logic [31:0] q;
        logic [31:0] r;
        logic [63:0] z;
        is_m = (op == OP_MULT) || (op == OP_MULTU);
        is_d = (op == OP_DIV) || (op == OP_DIVU);
        p_hi = exp_hi;
        p_lo = exp_lo;
        p_mf = 1'b0;
        p_mfdata = '0;
        p_to = 1'b0;
        p_dz = 1'b0;
        case (op)
            OP_MULT, OP_MULTU: begin
                if (mult_dead) p_to = 1'b1;
                else begin
                    z = mul_ref(op == OP_MULT, rs, rt);
                    p_hi = z[63:32];
                    p_lo = z[31:0];
                end
            end
            OP_DIV, OP_DIVU: begin
`ifdef MULDIV_DIV0_TRAP_EN
                if (rt == 32'd0) p_dz = 1'b1;
                else
`endif
                begin
                    div_ref(op == OP_DIV, rs, rt, q, r);
                    p_lo = q;
                    p_hi = r;
                end
            end
            OP_MTHI: p_hi = rs;
            OP_MTLO: p_lo = rs;
            OP_MFHI: begin
                p_mf = 1'b1;
                p_mfdata = exp_hi;
            end
            default: begin
                p_mf = 1'b1;
                p_mfdata = exp_lo;
            end
        endcase
        ms0 = ms_cnt;
        ds0 = ds_cnt;
        req_op = op;
        req_rs = rs;
        req_rt = rt;
        req_valid = 1'b1;
        n = 0;
        while (!req_ready && n < 100) begin
            tick;
            n++;
        end
        chk("accept", req_ready, 1);
        @(posedge clk);
        #1;
        if (hold_en) req_op = hold_op;
        else req_valid = 1'b0;
        n = 0;
        do begin
            tick;
            n++;
            if (!done) begin
                chk("inflight_ready", req_ready, 0);
                if (hold_en) chk("inflight_stall", stall, 1);
                if (is_m) begin
                    chk("mult_signed", mult_signed, op == OP_MULT);
                    chk("mult_ab", {mult_a, mult_b}, {rs, rt});
                end
                if (is_d) begin
                    chk("div_signed", div_signed, op == OP_DIV);
                    chk("div_ops", {div_dividend, div_divisor}, {rs, rt});
                end
            end
        end while (!done && n < 200);
        chk("latency", n, lat);
        chk("ready_after_done", req_ready, 1);
        chk("mult_start_cycles", ms_cnt - ms0, is_m ? 1 : 0);
        chk("div_start_cycles", ds_cnt - ds0, (is_d && !p_dz) ? 1 : 0);
    endtask

    initial begin
        repeat (3) tick;
        chk("rst_ready", req_ready, 0);
        chk("rst_outs", |{done, mf_valid, mf_data, hi, lo, mult_start,
                          mult_signed, mult_a, mult_b, div_start,
                          div_signed, div_dividend, div_divisor,
                          div_by_zero, timeout_err, stall}, 0);
        rst = 1'b1;
        tick;
        chk("ready_after_rst", req_ready, 1);

        hold_en = 1'b1;
        hold_op = OP_MFLO;
        run_op(OP_MULT, 32'hFFFF3F3F, 32'hFFFF7F7F, MB + 3);
        hold_en = 1'b0;
        chk("mult_hi_lit", hi, 32'h00000000);
        chk("mult_lo_lit", lo, 32'h60C1A141);
        run_op(OP_MFLO, 32'h0, 32'h0, 1);
        chk("mflo_lit", mf_data, 32'h60C1A141);

        run_op(OP_MULTU, 32'hFFFF3F3F, 32'hFFFF7F7F, MB + 3);
        chk("multu_hi_lit", hi, 32'hFFFEBEBE);
        chk("multu_lo_lit", lo, 32'h60C1A141);

        run_op(OP_DIV, 32'd100, 32'd7, DB + 3);
        chk("div_lo_lit", lo, 32'd14);
        chk("div_hi_lit", hi, 32'd2);
        run_op(OP_DIV, 32'hFFFFFFF9, 32'd2, DB + 3);
        chk("sdiv_lo_lit", lo, 32'hFFFFFFFD);
        chk("sdiv_hi_lit", hi, 32'hFFFFFFFF);
        run_op(OP_MFLO, 32'h0, 32'h0, 1);
        chk("sdiv_mflo_lit", mf_data, 32'hFFFFFFFD);
        run_op(OP_DIVU, 32'hFFFFFFF9, 32'd2, DB + 3);
        chk("divu_lo_lit", lo, 32'h7FFFFFFC);
        chk("divu_hi_lit", hi, 32'd1);

        run_op(OP_MTHI, 32'h12345678, 32'h0, 1);
        run_op(OP_MFHI, 32'h0, 32'h0, 1);
        chk("mfhi_lit", mf_data, 32'h12345678);
        run_op(OP_MTLO, 32'hCAFEF00D, 32'h0, 1);
        chk("mtlo_lit", lo, 32'hCAFEF00D);

`ifdef MULDIV_DIV0_TRAP_EN
        run_op(OP_DIVU, 32'd5, 32'd0, 1);
        chk("div0_hi_lit", hi, 32'h12345678);
        chk("div0_lo_lit", lo, 32'hCAFEF00D);
`else
        run_op(OP_DIVU, 32'd5, 32'd0, DB + 3);
        chk("div0_hi_lit", hi, 32'd5);
        chk("div0_lo_lit", lo, 32'hFFFFFFFF);
`endif

        mult_dead = 1'b1;
        run_op(OP_MULT, 32'd3, 32'd4, TO + 2);
        mult_dead = 1'b0;
`ifdef MULDIV_DIV0_TRAP_EN
        chk("to_hi_lit", hi, 32'h12345678);
        chk("to_lo_lit", lo, 32'hCAFEF00D);
`else
        chk("to_hi_lit", hi, 32'd5);
        chk("to_lo_lit", lo, 32'hFFFFFFFF);
`endif
        run_op(OP_MULTU, 32'd6, 32'd7, MB + 3);
        chk("b2b_lo_lit", lo, 32'd42);

        mult_dead = 1'b1;
        req_op = OP_MULT;
        req_rs = 32'd9;
        req_rt = 32'd9;
        req_valid = 1'b1;
        @(posedge clk);
        #1;
        req_valid = 1'b0;
        repeat (10) tick;
        chk("midop_ready", req_ready, 0);
        rst = 1'b0;
        tick;
        chk("midrst_ready", req_ready, 0);
        chk("midrst_outs", |{done, mf_valid, mf_data, hi, lo, mult_start,
                             mult_signed, mult_a, mult_b, div_start,
                             div_signed, div_dividend, div_divisor,
                             div_by_zero, timeout_err, stall}, 0);
        rst = 1'b1;
        mult_dead = 1'b0;
        tick;
        chk("ready_after_midrst", req_ready, 1);

        run_op(OP_MTLO, 32'h55, 32'h0, 1);
        run_op(OP_MFHI, 32'h0, 32'h0, 1);
        chk("post_rst_mfhi_lit", mf_data, 32'h0);
        chk("post_rst_lo_lit", lo, 32'h55);

        tick;
        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_chk, n_fail);
        $finish;
    end

endmodule
